imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Pipelined, multi-lane immediate generator for the processor decode stage. Accepts a bundle of up to LANES 32-bit instructions per cycle, classifies each by opcode group, and produces XLEN-wide extended immediates plus a format tag. Results go through a registered valid/ready stage with a skid entry, so decode back-pressure never drops a bundle. It also keeps a saturating illegal-format counter for debug.

## Interface
Parameters:
- XLEN, 32, immediate output width; legal values 32 or 64.
- LANES, 2, instructions per bundle; legal range 1..4.
- CNT_W, 16, width of illegal_count.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discards all buffered bundles.
- in_valid  in  1  input bundle valid.
- in_ready  out  1  block can accept a bundle this cycle.
- in_instr  in  LANES*32  instructions; lane i at [32*i+31:32*i].
- in_lane_en  in  LANES  per-lane valid mask.
- out_valid  out  1  output bundle valid.
- out_ready  in  1  consumer accepts the bundle.
- out_imm  out  LANES*XLEN  extended immediates; lane i at [XLEN*i+XLEN-1:XLEN*i].
- out_fmt  out  LANES*3  format tag per lane.
- out_lane_en  out  LANES  lane mask, registered with the bundle.
- illegal_count  out  CNT_W  saturating count of enabled illegal lanes.

## Operation
Per-lane classification uses op = instr[31:28]:
- 4'b0000 MEM: sign-extend instr[15:0]. fmt=3'd1.
- 4'b0001 ALU: if instr[26]=0, sign-extend instr[11:0]; if 1, zero-extend instr[11:0] (logical ops). fmt=3'd2.
- 4'b0110 UPPER: value {instr[19:0],12'b0}, then sign-extended from bit 31 to XLEN. fmt=3'd3.
- 4'b0111 BRANCH: sign-extend instr[25:0]. fmt=3'd4.
- Any other op ILLEGAL: imm=0. fmt=3'd7.

Lane and counter rules:
- Disabled lanes (in_lane_en[i]=0) produce imm=0 and fmt=3'd0 (NONE), whatever their op.
- illegal_count adds the number of enabled ILLEGAL lanes in each accepted bundle.
  - Accepted means in_valid && in_ready && !flush.
  - The counter saturates at all-ones.

Buffering is two entries: a main output register and one skid register.
- in_ready = !skid_full.
- When the main register is stalled (out_valid && !out_ready) and a bundle is accepted, that bundle goes to skid.
- When the main register drains, skid moves to main on the same edge. skid_full then clears.

## Timing
- Latency: a bundle accepted at edge N appears on out_* after edge N (visible in cycle N+1) if main is empty or draining.
- Throughput: one bundle per cycle while out_ready=1.
- out_* stays stable while out_valid && !out_ready.
- Simultaneous accept and drain with skid empty: the new bundle replaces main. No bubble.
- Simultaneous accept and drain with skid full: cannot occur, because in_ready=0.
- flush: at the edge, main and skid are invalidated and the input bundle is dropped. It is not counted. in_ready=1 the next cycle.
- flush has priority over all accept/drain activity in the same cycle.
- reset: out_valid=0, skid empty, out_imm=0, out_fmt=0, out_lane_en=0, illegal_count=0, in_ready=1 the cycle after reset.
- Reset asserted mid-stall loses buffered bundles. Flush does not clear illegal_count; reset does.

## Structure
- Package imm_gen_pkg holds:
  - opcode group constants OP_MEM, OP_ALU, OP_UPPER, OP_BRANCH;
  - fmt constants FMT_NONE/MEM/ALU/UPPER/BRANCH/ILLEGAL;
  - the 4-bit op field position.
- Sub-module imm_lane_ext is a combinational single-lane classifier and extender (instr, en → imm, fmt, illegal). It is instantiated LANES times in a generate loop.
- The top level holds the skid/valid logic and the counter.

## Test plan
- MEM/ALU extension, LANES=2, XLEN=32:
  - lane0=32'h0000_8001, lane1=32'h1000_0FFF, both enabled.
  - Required: imm0=32'hFFFF_8001, fmt 1; imm1=32'hFFFF_FFFF, fmt 2, one cycle later.
- ALU zero-extend and UPPER, XLEN=64:
  - lane0=32'h1400_0FFF, lane1=32'h6008_0000.
  - Required: imm0=64'h0000_0000_0000_0FFF; imm1=64'hFFFF_FFFF_8000_0000, fmt 3.
- BRANCH and disabled lane:
  - lane0=32'h7200_0000, lane1=32'h0000_0001 with in_lane_en=2'b01.
  - Required: imm0=32'hFE00_0000, fmt 4; lane1 imm=0, fmt 0.
- Back-pressure:
  - Hold out_ready=0 and send bundles A, B, C on consecutive cycles.
  - Required: A holds on the outputs, B is in skid, in_ready=0 when C is offered (C not accepted).
  - Raise out_ready: A, B, then a re-sent C emerge in order with no duplication.
- Illegal counting and saturation, CNT_W=2:
  - Send four bundles each with two enabled lanes of op 4'hF.
  - Required: illegal_count 2, then 3, then stays at 3; imm=0, fmt 7.
- Flush and reset:
  - With main and skid full, assert flush together with in_valid.
  - Required: out_valid=0 and in_ready=1 next cycle; counter unchanged.
  - Then assert reset: all outputs zero.

Source files
------------

// File: rtl/imm_gen_pkg.sv
// Shared constants for the immediate generator: opcode groups, format tags
// and the position of the 4-bit opcode-group field inside an instruction.
// Imported by the lane extender and the pipeline top level.
package imm_gen_pkg;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 28;
  localparam int OP_W   = OP_MSB - OP_LSB + 1;
  localparam int FMT_W  = 3;

  localparam logic [OP_W-1:0] OP_MEM    = 4'b0000;
  localparam logic [OP_W-1:0] OP_ALU    = 4'b0001;
  localparam logic [OP_W-1:0] OP_UPPER  = 4'b0110;
  localparam logic [OP_W-1:0] OP_BRANCH = 4'b0111;

  localparam logic [FMT_W-1:0] FMT_NONE    = 3'd0;
  localparam logic [FMT_W-1:0] FMT_MEM     = 3'd1;
  localparam logic [FMT_W-1:0] FMT_ALU     = 3'd2;
  localparam logic [FMT_W-1:0] FMT_UPPER   = 3'd3;
  localparam logic [FMT_W-1:0] FMT_BRANCH  = 3'd4;
  localparam logic [FMT_W-1:0] FMT_ILLEGAL = 3'd7;

endpackage

// File: rtl/imm_lane_ext.sv
// Single-lane classifier/extender: opcode group -> XLEN immediate + format tag.
// Purely combinational, zero latency; no handshake of its own.
// Disabled lanes always report NONE with a zero immediate and never flag illegal.
module imm_lane_ext
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]      instr,
  input  logic             en,
  output logic [XLEN-1:0]  imm,
  output logic [FMT_W-1:0] fmt,
  output logic             illegal
);

  logic [OP_W-1:0] op;
  assign op = instr[OP_MSB:OP_LSB];

  // Bit 27 sits between the opcode field and the ALU logical flag and
  // carries no immediate information.
  logic unused_gap_bit;
  assign unused_gap_bit = instr[27];

  // Fill the whole word with the extension bit, then overlay the payload.
  always_comb begin
    imm     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    if (en) begin
      case (op)
        OP_MEM: begin
          imm        = {XLEN{instr[15]}};
          imm[15:0]  = instr[15:0];
          fmt        = FMT_MEM;
        end
        OP_ALU: begin
          // instr[26] marks logical ops, which take a zero-extended immediate
          imm        = {XLEN{instr[11] & ~instr[26]}};
          imm[11:0]  = instr[11:0];
          fmt        = FMT_ALU;
        end
        OP_UPPER: begin
          imm        = {XLEN{instr[19]}};
          imm[31:0]  = {instr[19:0], 12'b0};
          fmt        = FMT_UPPER;
        end
        OP_BRANCH: begin
          imm        = {XLEN{instr[25]}};
          imm[25:0]  = instr[25:0];
          fmt        = FMT_BRANCH;
        end
        default: begin
          fmt        = FMT_ILLEGAL;
          illegal    = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Multi-lane immediate generator with a registered output stage plus one skid entry.
// Latency: one cycle from accept to out_valid when the output register is free or draining.
// Backpressure: in_ready drops only while the skid entry is occupied; no bundle is dropped.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int LANES = 2,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*32-1:0]    in_instr,
  input  logic [LANES-1:0]       in_lane_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*XLEN-1:0]  out_imm,
  output logic [LANES*FMT_W-1:0] out_fmt,
  output logic [LANES-1:0]       out_lane_en,
  output logic [CNT_W-1:0]       illegal_count
);

  logic [LANES*XLEN-1:0]  lane_imm;
  logic [LANES*FMT_W-1:0] lane_fmt;
  logic [LANES-1:0]       lane_ill;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    imm_lane_ext #(.XLEN(XLEN)) u_lane (
      .instr   (in_instr[32*i +: 32]),
      .en      (in_lane_en[i]),
      .imm     (lane_imm[XLEN*i +: XLEN]),
      .fmt     (lane_fmt[FMT_W*i +: FMT_W]),
      .illegal (lane_ill[i])
    );
  end

  logic                   main_vld;
  logic [LANES*XLEN-1:0]  main_imm;
  logic [LANES*FMT_W-1:0] main_fmt;
  logic [LANES-1:0]       main_en;
  logic                   skid_vld;
  logic [LANES*XLEN-1:0]  skid_imm;
  logic [LANES*FMT_W-1:0] skid_fmt;
  logic [LANES-1:0]       skid_en;

  logic accept;
  logic main_free;

  assign in_ready  = !skid_vld;
  assign accept    = in_valid && in_ready && !flush;
  // Main can take new content when empty or being consumed this cycle.
  assign main_free = !main_vld || out_ready;

  // Output register and skid entry; flush beats any accept/drain in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_vld <= 1'b0;
      main_imm <= '0;
      main_fmt <= '0;
      main_en  <= '0;
      skid_vld <= 1'b0;
      skid_imm <= '0;
      skid_fmt <= '0;
      skid_en  <= '0;
    end else if (flush) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (main_free) begin
      if (skid_vld) begin
        // in_ready is low here, so nothing new can arrive alongside
        main_vld <= 1'b1;
        main_imm <= skid_imm;
        main_fmt <= skid_fmt;
        main_en  <= skid_en;
        skid_vld <= 1'b0;
      end else if (accept) begin
        main_vld <= 1'b1;
        main_imm <= lane_imm;
        main_fmt <= lane_fmt;
        main_en  <= in_lane_en;
      end else begin
        main_vld <= 1'b0;
      end
    end else if (accept) begin
      skid_vld <= 1'b1;
      skid_imm <= lane_imm;
      skid_fmt <= lane_fmt;
      skid_en  <= in_lane_en;
    end
  end

  assign out_valid   = main_vld;
  assign out_imm     = main_imm;
  assign out_fmt     = main_fmt;
  assign out_lane_en = main_en;

  // Population count of enabled illegal lanes in the offered bundle.
  logic [2:0] ill_n;
  always_comb begin
    ill_n = 3'd0;
    for (int i = 0; i < LANES; i++) begin
      ill_n = ill_n + {2'b00, lane_ill[i]};
    end
  end

  logic [CNT_W-1:0] cnt;
  logic [CNT_W+2:0] cnt_sum;
  assign cnt_sum = {3'b000, cnt} + {{CNT_W{1'b0}}, ill_n};

  // Saturating debug counter; flush leaves it alone, reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (accept) begin
      if (|cnt_sum[CNT_W+2:CNT_W]) begin
        cnt <= '1;
      end else begin
        cnt <= cnt_sum[CNT_W-1:0];
      end
    end
  end

  assign illegal_count = cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Randomized plus directed bench for imm_gen_pipe with a scoreboard queue.
// Stimulus pushes expected bundles on accept; a monitor pops on each drain.
// Reference model works from the instruction-format rules with integer arithmetic.
module tb_imm_gen_pipe;

  localparam int XLEN  = 64;
  localparam int LANES = 2;
  localparam int CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic [LANES*XLEN-1:0] imm;
    logic [LANES*3-1:0]    fmt;
    logic [LANES-1:0]      en;
  } bundle_t;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  flush = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [LANES*32-1:0]   in_instr = '0;
  logic [LANES-1:0]      in_lane_en = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [LANES*XLEN-1:0] out_imm;
  logic [LANES*3-1:0]    out_fmt;
  logic [LANES-1:0]      out_lane_en;
  logic [CNT_W-1:0]      illegal_count;

  imm_gen_pipe #(.XLEN(XLEN), .LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_lane_en    (in_lane_en),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_imm       (out_imm),
    .out_fmt       (out_fmt),
    .out_lane_en   (out_lane_en),
    .illegal_count (illegal_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  bundle_t q[$];
  int      cnt_m = 0;
  logic    mon_en = 1'b0;

  logic    pend_acc = 1'b0;
  logic    pend_flush = 1'b0;
  logic    pend_rst = 1'b1;
  bundle_t pend_b;
  int      pend_n = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // Immediate rules evaluated as signed integers, then reduced to XLEN bits.
  function automatic void lane_model(input logic [31:0] ins, input logic en,
                                     output logic [XLEN-1:0] imm, output logic [2:0] fmt,
                                     output int ill);
    longint v;
    logic [63:0] bits;
    v = 0;
    fmt = 3'd0;
    ill = 0;
    if (en) begin
      case (ins[31:28])
        4'h0: begin
          v = longint'(ins[15:0]);
          if (v >= 32768) v = v - 65536;
          fmt = 3'd1;
        end
        4'h1: begin
          v = longint'(ins[11:0]);
          if (!ins[26] && v >= 2048) v = v - 4096;
          fmt = 3'd2;
        end
        4'h6: begin
          v = longint'(ins[19:0]) * 4096;
          if (v >= 64'sd2147483648) v = v - 64'sd4294967296;
          fmt = 3'd3;
        end
        4'h7: begin
          v = longint'(ins[25:0]);
          if (v >= 64'sd33554432) v = v - 64'sd67108864;
          fmt = 3'd4;
        end
        default: begin
          fmt = 3'd7;
          ill = 1;
        end
      endcase
    end
    bits = v;
    imm = bits[XLEN-1:0];
  endfunction

  // One clock of stimulus: settle the previous edge in the model, check in_ready, drive.
  task automatic step(input logic v, input logic [31:0] i0, input logic [31:0] i1,
                      input logic [1:0] en, input logic ordy, input logic fl, input logic rs);
    logic [XLEN-1:0] im;
    logic [2:0]      fm;
    int              il;
    logic [31:0]     ins [LANES];
    @(posedge clk);
    #1;
    if (pend_rst) begin
      q.delete();
      cnt_m = 0;
    end else if (pend_flush) begin
      q.delete();
    end else if (pend_acc) begin
      q.push_back(pend_b);
      cnt_m = (cnt_m + pend_n > CNT_MAX) ? CNT_MAX : cnt_m + pend_n;
    end
    if (mon_en) chk("in_ready", {127'd0, in_ready}, {127'd0, q.size() < 2});
    ins[0] = i0;
    ins[1] = i1;
    pend_n = 0;
    for (int k = 0; k < LANES; k++) begin
      lane_model(ins[k], en[k], im, fm, il);
      pend_b.imm[XLEN*k +: XLEN] = im;
      pend_b.fmt[3*k +: 3] = fm;
      pend_n += il;
    end
    pend_b.en = en;
    pend_acc = v && (q.size() < 2) && !fl && !rs;
    pend_flush = fl;
    pend_rst = rs;
    reset = rs;
    flush = fl;
    in_valid = v;
    in_instr = {i1, i0};
    in_lane_en = en;
    out_ready = ordy;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'h0, 32'h0, 2'b00, ordy, 1'b0, 1'b0);
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_out_imm", {{(128-LANES*XLEN){1'b0}}, out_imm}, 128'd0);
    chk("rst_out_fmt", {122'd0, out_fmt}, 128'd0);
    chk("rst_out_lane_en", {126'd0, out_lane_en}, 128'd0);
    chk("rst_illegal_count", {126'd0, illegal_count}, 128'd0);
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [3:0] op;
    logic [31:0] r;
    case ($urandom_range(0, 4))
      0: op = 4'h0;
      1: op = 4'h1;
      2: op = 4'h6;
      3: op = 4'h7;
      default: op = 4'($urandom_range(0, 15));
    endcase
    r = $urandom;
    return {op, r[27:0]};
  endfunction

  // Monitor: compare the presented bundle with the queue head, pop on drain.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", {127'd0, out_valid}, {127'd0, q.size() != 0});
      if (out_valid && q.size() != 0) begin
        chk("out_imm", {{(128-LANES*XLEN){1'b0}}, out_imm}, {{(128-LANES*XLEN){1'b0}}, q[0].imm});
        chk("out_fmt", {122'd0, out_fmt}, {122'd0, q[0].fmt});
        chk("out_lane_en", {126'd0, out_lane_en}, {126'd0, q[0].en});
        if (out_ready) void'(q.pop_front());
      end
      chk("illegal_count", {126'd0, illegal_count}, 128'(cnt_m));
    end
  end

  initial begin
    step(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    mon_en = 1'b1;
    check_reset_state();

    // Extension patterns: MEM/ALU signed, ALU logical/UPPER, BRANCH with a disabled lane
    step(1'b1, 32'h0000_8001, 32'h1000_0FFF, 2'b11, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h1400_0FFF, 32'h6008_0000, 2'b11, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h7200_0000, 32'h0000_0001, 2'b01, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h0000_7FFF, 32'h7000_0001, 2'b11, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Back-pressure: A held, B in skid, C refused, then resent once space opens
    step(1'b1, 32'h0000_1111, 32'h1000_0222, 2'b11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h6000_1333, 32'h7000_0444, 2'b11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h1400_0555, 32'h0000_F666, 2'b11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h1400_0555, 32'h0000_F666, 2'b11, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    step(1'b1, 32'h1400_0555, 32'h0000_F666, 2'b11, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Illegal counting up to saturation
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 32'hF000_0000 | k, 32'hF123_4567, 2'b11, 1'b1, 1'b0, 1'b0);
    end
    idle(1'b1);
    idle(1'b1);

    // Flush with both entries full and a valid illegal bundle offered
    step(1'b1, 32'h0000_0ABC, 32'h1000_0DEF, 2'b11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h6000_0001, 32'h7000_0002, 2'b11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hE000_0000, 32'hD000_0000, 2'b11, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    step(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    check_reset_state();

    // Random traffic: random lanes, masks, stalls and occasional flushes
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), rand_instr(), 2'($urandom_range(0, 3)),
           $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0, 1'b0);
    end

    // Drain within a bounded budget
    for (int n = 0; n < 20; n++) begin
      idle(1'b1);
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
